// File: rtl/data_chk_if.sv
// data_chk_if: stream handshake between the data source and the data_chk sink.
//   TDATA  32-bit beat from source
//   VALID  beat present
//   TREADY sink ready; a beat transfers when VALID & TREADY
interface data_chk_if;
  logic [31:0] TDATA;
  logic        VALID;
  logic        TREADY;
  modport master (output TDATA, VALID, input TREADY);
  modport slave  (input TDATA, VALID, output TREADY);
endinterface

// File: rtl/data_chk.sv
// data_chk: receive-side checker that locks to an incrementing stream and counts beats/mismatches.
//   ACLK/RSTN   clock, asynchronous active-low reset
//   en          checker enable (0 forces IDLE); CLR synchronously clears the counters
//   s           stream slave (TDATA, VALID in; TREADY out, a registered copy of en)
//   LOCKED      FSM in CHECK; ERR one-cycle pulse per mismatching beat
//   ERR_CNT     saturating mismatch count; RX_CNT saturating accepted-beat count
//   ERR_STICKY  mismatch seen since CLR/reset when DATA_CHK_STICKY_EN is defined, else 0
module data_chk #(
  parameter logic [31:0] INC      = 32'd1,
  parameter int          ERR_W    = 16,
  parameter int          LOSS_THR = 4
) (
  input  logic             ACLK,
  input  logic             RSTN,
  input  logic             en,
  input  logic             CLR,
  data_chk_if.slave        s,
  output logic             LOCKED,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [31:0]      RX_CNT,
  output logic             ERR_STICKY
);
  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;
  localparam logic [3:0] THR = 4'(LOSS_THR);
  state_t      state, state_n;
  logic [31:0] exp_d;
  logic [3:0]  loss, loss_inc, loss_n;
  logic        acc, live, chk, mis, drop;
  // The generator never emits 0, so INC is also a valid successor when 0 is expected.
  always_comb begin
    acc      = s.VALID & s.TREADY;
    live     = acc & (state != IDLE);
    chk      = acc & (state == CHECK);
    mis      = chk & (s.TDATA != exp_d) & ~((exp_d == '0) & (s.TDATA == INC));
    loss_inc = loss + 4'd1;
    drop     = mis & (loss_inc == THR);
    state_n  = !en ? IDLE : state == IDLE ? SYNC : (state == SYNC && acc) ? CHECK : drop ? SYNC : state;
    loss_n   = state_n != CHECK ? 4'd0 : mis ? loss_inc : chk ? 4'd0 : loss;
    LOCKED   = state == CHECK;
  end
  always_ff @(posedge ACLK or negedge RSTN)
    if (!RSTN) state <= IDLE;
    else state <= state_n;
  // Every accepted beat reloads the expectation, so a mismatch resyncs to the new data.
  always_ff @(posedge ACLK or negedge RSTN) begin
    if (!RSTN) begin
      s.TREADY <= 1'b0;
      exp_d    <= '0;
      loss     <= '0;
      ERR      <= 1'b0;
      ERR_CNT  <= '0;
      RX_CNT   <= '0;
    end else begin
      s.TREADY <= en;
      exp_d    <= live ? s.TDATA + INC : exp_d;
      loss     <= loss_n;
      ERR      <= mis;
      ERR_CNT  <= CLR ? '0 : (mis && ~&ERR_CNT) ? ERR_CNT + ERR_W'(1) : ERR_CNT;
      RX_CNT   <= CLR ? '0 : (live && ~&RX_CNT) ? RX_CNT + 32'd1 : RX_CNT;
    end
  end
`ifdef DATA_CHK_STICKY_EN
  // A mismatch on the same edge as CLR still leaves the flag set.
  always_ff @(posedge ACLK or negedge RSTN)
    if (!RSTN) ERR_STICKY <= 1'b0;
    else ERR_STICKY <= mis | (ERR_STICKY & ~CLR);
`else
  assign ERR_STICKY = 1'b0;
`endif
endmodule

// File: tb/tb_data_chk.sv
// tb_data_chk: self-checking bench for data_chk (vector table, reference model, scoreboard).
module tb_data_chk;
  localparam logic [31:0] INC = 32'd1;
  localparam int LOSS_THR = 4;
`ifdef DATA_CHK_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif
  localparam int IDL = 0, SYN = 1, CHK = 2;

  logic clk = 1'b0, rstn = 1'b1, en = 1'b0, clr = 1'b0;
  logic locked, err, sticky;
  logic [15:0] err_cnt;
  logic [31:0] rx_cnt;
  data_chk_if bus ();

  data_chk #(.INC(INC), .ERR_W(16), .LOSS_THR(LOSS_THR)) dut (
    .ACLK(clk), .RSTN(rstn), .en(en), .CLR(clr), .s(bus),
    .LOCKED(locked), .ERR(err), .ERR_CNT(err_cnt), .RX_CNT(rx_cnt), .ERR_STICKY(sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tready, locked, err;
    logic [15:0] ecnt;
    logic [31:0] rx;
    logic        sticky;
  } obs_t;
  obs_t sb[$];

  int passed = 0, total = 0;
  int m_st = IDL, m_loss = 0;
  logic m_tready = 0, m_err = 0, m_sticky = 0;
  logic [31:0] m_exp = 0, m_rx = 0;
  logic [15:0] m_ecnt = 0;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic model_reset();
    m_st = IDL; m_loss = 0; m_tready = 0; m_err = 0; m_sticky = 0;
    m_exp = 0; m_rx = 0; m_ecnt = 0;
  endtask

  // Reference behaviour for one rising edge with the given inputs.
  task automatic model_edge(input logic v, input logic [31:0] d, input logic e, input logic c);
    logic acc, mis;
    acc = v && m_tready;
    mis = 0;
    if (acc && m_st == CHK) mis = !(d == m_exp || (m_exp == 0 && d == INC));
    if (acc && m_st != IDL) begin
      m_exp = d + INC;
      if (m_rx != 32'hFFFF_FFFF) m_rx = m_rx + 1;
    end
    if (mis && m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 1;
    if (c) begin m_rx = 0; m_ecnt = 0; end
    m_sticky = STK && (mis || (m_sticky && !c));
    m_err = mis;
    if (!e) m_st = IDL;
    else if (m_st == IDL) m_st = SYN;
    else if (m_st == SYN && acc) m_st = CHK;
    else if (m_st == CHK && acc) begin
      if (mis) begin
        m_loss++;
        if (m_loss == LOSS_THR) m_st = SYN;
      end else m_loss = 0;
    end
    if (m_st != CHK) m_loss = 0;
    m_tready = e;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic e, input logic c);
    obs_t x;
    @(negedge clk);
    bus.VALID = v; bus.TDATA = d; en = e; clr = c;
    model_edge(v, d, e, c);
    sb.push_back({m_tready, m_st == CHK, m_err, m_ecnt, m_rx, m_sticky});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      x = sb.pop_front();
      check("tready", bus.TREADY, x.tready);
      check("locked", locked, x.locked);
      check("err", err, x.err);
      check("err_cnt", err_cnt, x.ecnt);
      check("rx_cnt", rx_cnt, x.rx);
      check("sticky", sticky, x.sticky);
    end
  endtask

  task automatic check_zero(input string n);
    check({n, "_tready"}, bus.TREADY, 0);
    check({n, "_locked"}, locked, 0);
    check({n, "_err"}, err, 0);
    check({n, "_err_cnt"}, err_cnt, 0);
    check({n, "_rx_cnt"}, rx_cnt, 0);
    check({n, "_sticky"}, sticky, 0);
  endtask

  typedef struct {
    logic v;
    logic [31:0] d;
    logic e;
    logic err;
    logic lk;
  } vec_t;
  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl = '{
      '{0, 0, 0, 0, 0}, '{0, 0, 1, 0, 0},
      '{1, 10, 1, 0, 1}, '{1, 11, 1, 0, 1}, '{1, 12, 1, 0, 1},
      '{1, 50, 1, 1, 1}, '{1, 51, 1, 0, 1}, '{1, 52, 1, 0, 1},
      '{1, 7, 1, 1, 1}, '{1, 3, 1, 1, 1}, '{1, 9, 1, 1, 1}, '{1, 1, 1, 1, 0},
      '{1, 20, 1, 0, 1}, '{1, 21, 1, 0, 1}, '{1, 22, 1, 0, 1}
    };
    bus.VALID = 0; bus.TDATA = 0;
    #3 rstn = 0;
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    model_reset();
    // Lock onto 1..100
    step(0, 0, 1, 0);
    step(1, 1, 1, 0);
    check("t1_locked_beat1", locked, 1);
    for (int i = 2; i <= 100; i++) step(1, i, 1, 0);
    check("t1_rx", rx_cnt, 100);
    check("t1_errcnt", err_cnt, 0);
    check("t1_locked", locked, 1);
    // Resync, single mismatch, then loss of lock and recovery
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].e, 0);
      check($sformatf("tbl%0d_err", i), err, tbl[i].err);
      check($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
    end
    check("t3_errcnt", err_cnt, 5);
    check("t3_rx", rx_cnt, 113);
    // Wrap through zero with an idle cycle
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 32'hFFFF_FFFE, 1, 0);
    step(1, 32'hFFFF_FFFF, 1, 0);
    step(0, 32'h1234_5678, 1, 0);
    step(1, 1, 1, 0);
    check("t4_zero_skip_err", err, 0);
    step(1, 2, 1, 0);
    check("t4_errcnt", err_cnt, 5);
    check("t4_locked", locked, 1);
    // CLR together with a mismatching beat
    step(1, 77, 1, 1);
    check("t5_err", err, 1);
    check("t5_errcnt", err_cnt, 0);
    check("t5_rx", rx_cnt, 0);
    check("t5_sticky", sticky, STK);
    step(0, 0, 1, 0);
    check("t5_sticky_hold", sticky, STK);
    step(0, 0, 1, 1);
    check("t5_sticky_clr", sticky, 0);
    // en drops while a beat is in flight: that beat is still checked
    step(1, 500, 0, 0);
    check("en_fall_err", err, 1);
    check("en_fall_locked", locked, 0);
    step(1, 501, 0, 0);
    check("en_fall_rx", rx_cnt, 1);
    // Asynchronous reset mid-stream
    step(0, 0, 1, 0);
    step(1, 5, 1, 0);
    step(1, 9, 1, 0);
    step(1, 20, 1, 0);
    check("t6_errcnt", err_cnt, 3);
    #2 rstn = 0;
    #1 check_zero("async_rst");
    rstn = 1;
    model_reset();
    step(1, 1000, 1, 0);
    step(1, 1000, 1, 0);
    check("t6_first_err", err, 0);
    step(1, 1001, 1, 0);
    check("t6_next_err", err, 0);
    check("t6_locked", locked, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
